// File: rtl/useq_loader.sv
// Byte-stream loader for a microsequencer program RAM: header, length, data, zero-fill, checksum, then release core reset.
// Program RAM reads are combinational; s_ready drops only while the tail of the RAM is being zero-filled.
module useq_loader #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       core_rst_n,
  input  logic [7:0] core_addr,
  output logic [7:0] core_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_FILL,
    S_CSUM,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_len;
  logic [8:0]  w_len_nxt;
  logic [7:0]  r_addr;
  logic [7:0]  w_addr_nxt;
  logic [7:0]  r_csum;
  logic [7:0]  w_csum_nxt;
  logic [15:0] r_tcnt;
  logic [15:0] w_tcnt_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic        r_core_rst_n;

  logic        w_accept;
  logic        w_timed;
  logic        w_last_data;
  logic        w_ram_we;
  logic [7:0]  w_ram_wdat;

  logic [7:0]  r_ram [0:255];

  assign s_ready     = (r_state != S_FILL);
  assign w_accept    = s_valid & s_ready;
  assign w_timed     = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  // 9-bit compare so a 256-byte frame ends at address 255 and lets r_addr wrap to 0
  assign w_last_data = (({1'b0, r_addr} + 9'd1) == r_len);

  assign busy       = w_timed || (r_state == S_FILL);
  assign done       = (r_state == S_RUN);
  assign err        = r_err;
  assign core_rst_n = r_core_rst_n;
  assign core_data  = r_ram[core_addr];

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_csum_nxt  = r_csum;
    w_tcnt_nxt  = 16'd0;
    w_err_nxt   = r_err;
    w_ram_we    = 1'b0;
    w_ram_wdat  = s_data;

    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_accept && (s_data == HEADER)) begin
          w_state_nxt = S_LEN;
          w_err_nxt   = 1'b0;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          w_len_nxt   = (s_data == 8'h00) ? 9'd256 : {1'b0, s_data};
          w_addr_nxt  = 8'h00;
          w_csum_nxt  = 8'h00;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_ram_we   = 1'b1;
          w_addr_nxt = r_addr + 8'd1;
          w_csum_nxt = r_csum + s_data;
          if (w_last_data) begin
            w_state_nxt = (r_len == 9'd256) ? S_CSUM : S_FILL;
          end
        end
      end
      S_FILL: begin
        w_ram_we   = 1'b1;
        w_ram_wdat = 8'h00;
        w_addr_nxt = r_addr + 8'd1;
        if (r_addr == 8'hFF) begin
          w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          if (s_data == r_csum) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // An accepted byte always beats an expiring idle count.
    if (w_timed && !w_accept) begin
      if (r_tcnt == (TIMEOUT - 16'd1)) begin
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b1;
      end else begin
        w_tcnt_nxt = r_tcnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= 9'd0;
      r_addr       <= 8'h00;
      r_csum       <= 8'h00;
      r_tcnt       <= 16'd0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_addr       <= w_addr_nxt;
      r_csum       <= w_csum_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_err        <= w_err_nxt;
      r_core_rst_n <= (w_state_nxt == S_RUN);
    end
  end

  // Program RAM survives reset so an aborted load leaves earlier bytes intact.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[r_addr] <= w_ram_wdat;
    end
  end

endmodule

// File: tb/tb_useq_loader.sv
// Randomized frame-level bench for useq_loader with a byte-array reference model of the program RAM.
module tb_useq_loader;

  localparam logic [7:0] HDR = 8'hA5;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       core_rst_n;
  logic [7:0] core_addr;
  logic [7:0] core_data;
  logic       busy;
  logic       done;
  logic       err;

  useq_loader #(.HEADER(HDR), .TIMEOUT(16'd16)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .core_rst_n (core_rst_n),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         last_stalls;
  logic [7:0] mdl_ram [256];
  logic       mdl_done;
  logic       mdl_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; waits `gap` idle cycles, then holds the byte until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int stalls;
    stalls = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && stalls < 400) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 400) check("ready_wait", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid     = 1'b0;
    last_stalls = stalls;
  endtask

  task automatic ram_sweep(input string tag);
    for (int a = 0; a < 256; a++) begin
      core_addr = a[7:0];
      #1;
      check({tag, "_ram"}, {24'd0, core_data}, {24'd0, mdl_ram[a]});
    end
  endtask

  // cs_mode: -1 correct checksum, -2 random wrong checksum, otherwise that literal byte.
  task automatic load_frame(input string tag, input byte_q_t q, input int cs_mode, input int maxgap);
    int         n;
    logic [7:0] sum;
    logic [7:0] cs;
    logic [7:0] lb;
    logic       good;
    n   = q.size();
    sum = 8'h00;
    lb  = n[7:0];
    send_byte(HDR, $urandom_range(maxgap, 0));
    check({tag, "_hdr_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_hdr_err"}, {31'd0, err}, 32'd0);
    send_byte(lb, $urandom_range(maxgap, 0));
    for (int i = 0; i < n; i++) begin
      send_byte(q[i], $urandom_range(maxgap, 0));
      mdl_ram[i] = q[i];
      sum        = sum + q[i];
    end
    for (int i = n; i < 256; i++) mdl_ram[i] = 8'h00;
    if (cs_mode == -1)      cs = sum;
    else if (cs_mode == -2) cs = sum + 8'($urandom_range(254, 1));
    else                    cs = cs_mode[7:0];
    good = (cs == sum);
    send_byte(cs, 0);
    check({tag, "_fill_cycles"}, last_stalls, 256 - n);
    check({tag, "_done"}, {31'd0, done}, {31'd0, good});
    check({tag, "_err"}, {31'd0, err}, {31'd0, !good});
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, good});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    mdl_done = good;
    mdl_err  = !good;
    ram_sweep(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t q;
    logic [7:0] b;
    int n;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    core_addr = 8'h00;
    @(posedge clk);
    #1;
    check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of DATA aborts the load
    send_byte(HDR, 0);
    send_byte(8'h05, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #2;
    check("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h11, 0);
    check("idle_discard_busy", {31'd0, busy}, 32'd0);
    check("idle_discard_done", {31'd0, done}, 32'd0);

    q = '{8'h11, 8'h22, 8'h33};
    load_frame("short", q, -1, 0);
    check("short_fill253", last_stalls, 253);
    core_addr = 8'h01;
    #1;
    check("short_addr1", {24'd0, core_data}, 32'h22);

    q = '{8'h10};
    load_frame("badcs", q, 8'h11, 0);
    load_frame("goodcs", q, 8'h10, 0);

    q = {};
    for (int i = 0; i < 256; i++) q.push_back(i[7:0]);
    load_frame("full", q, 8'h80, 0);
    core_addr = 8'hFF;
    #1;
    check("full_ramFF", {24'd0, core_data}, 32'hFF);

    // Reload while running, then let the LEN wait expire
    send_byte(HDR, 0);
    check("reload_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("reload_done", {31'd0, done}, 32'd0);
    check("reload_busy", {31'd0, busy}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("len_to_err", {31'd0, err}, 32'd1);
    check("len_to_busy", {31'd0, busy}, 32'd0);

    // Timeout 16 cycles after last data byte; RAM keeps what was written
    send_byte(HDR, 0);
    check("to_hdr_err_clr", {31'd0, err}, 32'd0);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    mdl_ram[0] = 8'h01;
    repeat (15) @(posedge clk);
    #1;
    check("to_15_busy", {31'd0, busy}, 32'd1);
    check("to_15_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    check("to_16_busy", {31'd0, busy}, 32'd0);
    check("to_16_err", {31'd0, err}, 32'd1);
    check("to_16_done", {31'd0, done}, 32'd0);
    core_addr = 8'h00;
    #1;
    check("to_ram_kept", {24'd0, core_data}, {24'd0, mdl_ram[0]});

    // A byte on the 16th idle cycle beats the timeout
    send_byte(HDR, 0);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h07, 15);
    check("to_save_err", {31'd0, err}, 32'd0);
    check("to_save_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h08, 0);
    check("to_save_fill", last_stalls, 254);
    check("to_save_done", {31'd0, done}, 32'd1);
    mdl_ram[1] = 8'h07;
    for (int i = 2; i < 256; i++) mdl_ram[i] = 8'h00;
    ram_sweep("to_save");
    mdl_done = 1'b1;
    mdl_err  = 1'b0;

    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(3, 0)) begin
        b = 8'($urandom);
        if (b == HDR) b = b ^ 8'h01;
        send_byte(b, $urandom_range(2, 0));
      end
      check("rnd_garbage_done", {31'd0, done}, {31'd0, mdl_done});
      check("rnd_garbage_err", {31'd0, err}, {31'd0, mdl_err});
      case ($urandom_range(3, 0))
        0:       n = 1;
        1:       n = 255;
        2:       n = 256;
        default: n = $urandom_range(256, 1);
      endcase
      q = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(7, 0) == 0) q.push_back(HDR);
        else                          q.push_back(8'($urandom));
      end
      load_frame("rnd", q, ($urandom_range(3, 0) == 0) ? -2 : -1, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
